// File: rtl/player_missile_ctrl.sv
// Player missile engine: fixed pool of missile slots launched from the player column,
// moved upward on a divided motion tick and retired at the screen top or on a hit.
module player_missile_ctrl #(
  parameter int unsigned NUM_MISSILES   = 3,
  parameter int unsigned COORD_W        = 12,
  parameter int unsigned TICK_DIV       = 1000000,
  parameter int unsigned MISSILE_STEP   = 2,
  parameter int unsigned MISSILE_LEN    = 3,
  parameter int unsigned SPAWN_ROW      = 458,
  parameter int unsigned PLAYER_W       = 16,
  parameter int unsigned COOLDOWN_TICKS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [COORD_W-1:0]                  pixel_row,
  input  logic [COORD_W-1:0]                  pixel_column,
  input  logic [COORD_W-1:0]                  player_col,
  input  logic                                fire,
  input  logic [NUM_MISSILES-1:0]             hit,
  output logic [NUM_MISSILES-1:0]             missile_in_flight,
  output logic [NUM_MISSILES-1:0]             missile_active,
  output logic [3:0]                          missile_output,
  output logic [$clog2(NUM_MISSILES+1)-1:0]   in_flight_count,
  output logic                                fire_ack,
  output logic                                fire_drop
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam int unsigned CdW  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam int unsigned NumW = $clog2(NUM_MISSILES + 1);

  localparam logic [COORD_W-1:0] SpawnRow = COORD_W'(SPAWN_ROW);
  localparam logic [COORD_W-1:0] Step     = COORD_W'(MISSILE_STEP);
  localparam logic [COORD_W-1:0] HalfW    = COORD_W'(PLAYER_W / 2);
  localparam logic [CntW-1:0]    CntMax   = CntW'(TICK_DIV - 1);
  localparam logic [CdW-1:0]     CdInit   = CdW'(COOLDOWN_TICKS);
  localparam logic [COORD_W:0]   LenExt   = (COORD_W + 1)'(MISSILE_LEN);

  logic [NUM_MISSILES-1:0] in_flight_q, in_flight_d;
  logic [COORD_W-1:0]      row_q [NUM_MISSILES];
  logic [COORD_W-1:0]      row_d [NUM_MISSILES];
  logic [COORD_W-1:0]      col_q [NUM_MISSILES];
  logic [COORD_W-1:0]      col_d [NUM_MISSILES];
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CdW-1:0]          cd_q, cd_d;
  logic                    fire_q;
  logic                    ack_q, drop_q;

  logic                    tick, fire_rise, launch, found;
  logic [NUM_MISSILES-1:0] sel_oh;
  logic [COORD_W-1:0]      launch_col;

  always_comb begin
    tick       = (cnt_q == CntMax);
    fire_rise  = fire & ~fire_q;
    launch_col = player_col + HalfW;

    // Lowest-index free slot, judged on registered state only.
    sel_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (!in_flight_q[i] && !found) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
      end
    end
    launch = fire_rise && (cd_q == '0) && found;

    in_flight_d = in_flight_q;
    row_d       = row_q;
    col_d       = col_q;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (launch && sel_oh[i]) begin
        in_flight_d[i] = 1'b1;
        row_d[i]       = SpawnRow;
        col_d[i]       = launch_col;
      end else if (in_flight_q[i] && hit[i]) begin
        in_flight_d[i] = 1'b0;
        row_d[i]       = SpawnRow;
      end else if (in_flight_q[i] && tick) begin
        if (row_q[i] < Step) begin
          in_flight_d[i] = 1'b0;
          row_d[i]       = SpawnRow;
        end else begin
          row_d[i] = row_q[i] - Step;
        end
      end
    end

    if (launch) begin
      cd_d = CdInit;
    end else if (tick && (cd_q != '0)) begin
      cd_d = cd_q - CdW'(1);
    end else begin
      cd_d = cd_q;
    end

    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= '0;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        row_q[i] <= SpawnRow;
        col_q[i] <= '0;
      end
      cnt_q  <= '0;
      cd_q   <= '0;
      fire_q <= 1'b1;  // a button held through reset must not launch
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      cd_q        <= cd_d;
      fire_q      <= fire;
      ack_q       <= launch;
      drop_q      <= fire_rise & ~launch;
    end
  end

  // Extended compares so row+MISSILE_LEN cannot wrap.
  always_comb begin
    missile_active  = '0;
    in_flight_count = '0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      missile_active[i] = in_flight_q[i]
                        && ({1'b0, row_q[i]} < {1'b0, pixel_row})
                        && ({1'b0, pixel_row} < ({1'b0, row_q[i]} + LenExt))
                        && (pixel_column == col_q[i]);
      in_flight_count   = in_flight_count + NumW'(in_flight_q[i]);
    end
  end

  assign missile_in_flight = in_flight_q;
  assign missile_output    = (|missile_active) ? 4'hF : 4'h0;
  assign fire_ack          = ack_q;
  assign fire_drop         = drop_q;

endmodule

// File: tb/tb_player_missile_ctrl.sv
// Directed bench for player_missile_ctrl with TICK_DIV=4 and COOLDOWN_TICKS=2.
module tb_player_missile_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_row, pixel_column, player_col;
  logic        fire;
  logic [2:0]  hit;
  logic [2:0]  missile_in_flight, missile_active;
  logic [3:0]  missile_output;
  logic [1:0]  in_flight_count;
  logic        fire_ack, fire_drop;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  player_missile_ctrl #(
    .NUM_MISSILES  (3),
    .COORD_W       (12),
    .TICK_DIV      (4),
    .MISSILE_STEP  (2),
    .MISSILE_LEN   (3),
    .SPAWN_ROW     (458),
    .PLAYER_W      (16),
    .COOLDOWN_TICKS(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pixel_row        (pixel_row),
    .pixel_column     (pixel_column),
    .player_col       (player_col),
    .fire             (fire),
    .hit              (hit),
    .missile_in_flight(missile_in_flight),
    .missile_active   (missile_active),
    .missile_output   (missile_output),
    .in_flight_count  (in_flight_count),
    .fire_ack         (fire_ack),
    .fire_drop        (fire_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle index n = number of posedges since reset release; ticks land on n % 4 == 0.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic probe(input int r, input int c, input string tag, input logic [2:0] exp);
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    #1;
    chk(tag, 32'(missile_active), 32'(exp));
    chk({tag, "_out"}, 32'(missile_output), (exp != 3'b0) ? 32'hF : 32'h0);
  endtask

  initial begin
    rst = 1'b1; fire = 1'b1; hit = '0; player_col = 12'd312;
    pixel_row = '0; pixel_column = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inflight", 32'(missile_in_flight), 0);
    chk("rst_count", 32'(in_flight_count), 0);
    chk("rst_ack", 32'(fire_ack), 0);
    chk("rst_drop", 32'(fire_drop), 0);
    rst = 1'b0; cyc = 0;

    // Fire held through reset must not launch.
    for (int k = 0; k < 10; k++) begin
      step();
      chk("held_ack", 32'(fire_ack), 0);
    end
    chk("held_count", 32'(in_flight_count), 0);

    fire = 1'b0; step();            // 11
    fire = 1'b1; step();            // 12: launch coincides with a tick
    chk("l0_ack", 32'(fire_ack), 1);
    chk("l0_inflight", 32'(missile_in_flight), 3'b001);
    chk("l0_count", 32'(in_flight_count), 1);
    probe(459, 320, "l0_top", 3'b001);
    probe(460, 320, "l0_bot", 3'b001);
    probe(458, 320, "l0_above", 3'b000);
    probe(461, 320, "l0_below", 3'b000);
    fire = 1'b0; step();            // 13
    chk("l0_ack_pulse", 32'(fire_ack), 0);

    step();                         // 14
    fire = 1'b1; step();            // 15: cooldown 2 -> drop
    chk("cd2_drop", 32'(fire_drop), 1);
    chk("cd2_ack", 32'(fire_ack), 0);
    chk("cd2_count", 32'(in_flight_count), 1);
    fire = 1'b0; step();            // 16: tick, row0 456
    probe(457, 320, "mv1_in", 3'b001);
    probe(459, 320, "mv1_old", 3'b000);
    probe(457, 321, "mv1_col", 3'b000);
    fire = 1'b1; step();            // 17: cooldown 1 -> drop
    chk("cd1_drop", 32'(fire_drop), 1);
    fire = 1'b0;

    step_to(20);                    // row0 454, cooldown 0
    probe(455, 320, "mv2_in", 3'b001);
    fire = 1'b1; player_col = 12'd100; step();  // 21
    chk("l1_ack", 32'(fire_ack), 1);
    chk("l1_inflight", 32'(missile_in_flight), 3'b011);
    chk("l1_count", 32'(in_flight_count), 2);
    probe(459, 108, "l1_pix", 3'b010);
    fire = 1'b0;

    step_to(28);
    fire = 1'b1; player_col = 12'd200; step();  // 29
    chk("l2_ack", 32'(fire_ack), 1);
    chk("l2_inflight", 32'(missile_in_flight), 3'b111);
    chk("l2_count", 32'(in_flight_count), 3);
    probe(459, 208, "l2_pix", 3'b100);
    fire = 1'b0;

    step_to(36);
    fire = 1'b1; step();            // 37: no free slot
    chk("full_drop", 32'(fire_drop), 1);
    chk("full_ack", 32'(fire_ack), 0);
    chk("full_count", 32'(in_flight_count), 3);
    probe(447, 320, "full_r0", 3'b001);
    probe(451, 108, "full_r1", 3'b010);
    probe(455, 208, "full_r2", 3'b100);
    fire = 1'b0; step();            // 38

    hit = 3'b100; step();           // 39
    chk("hit2_inflight", 32'(missile_in_flight), 3'b011);
    chk("hit2_count", 32'(in_flight_count), 2);
    // Hit slot1 and fire together: launch must go to slot2.
    hit = 3'b010; fire = 1'b1; player_col = 12'd40; step();  // 40
    chk("hitfire_ack", 32'(fire_ack), 1);
    chk("hitfire_drop", 32'(fire_drop), 0);
    chk("hitfire_inflight", 32'(missile_in_flight), 3'b101);
    probe(459, 48, "hitfire_pix", 3'b100);
    probe(445, 320, "hitfire_r0", 3'b001);
    fire = 1'b0; hit = 3'b010; step();  // 41: hit on idle slot1
    chk("idlehit_inflight", 32'(missile_in_flight), 3'b101);
    chk("idlehit_ack", 32'(fire_ack), 0);
    chk("idlehit_drop", 32'(fire_drop), 0);
    hit = 3'b000;

    step_to(928);                   // row0 reaches 0
    probe(1, 320, "top_row1", 3'b001);
    probe(0, 320, "top_row0", 3'b000);
    step_to(931);
    chk("top_hold", 32'(missile_in_flight), 3'b101);
    step();                         // 932: row<2 on tick -> retire
    chk("top_retire", 32'(missile_in_flight), 3'b100);
    chk("top_count", 32'(in_flight_count), 1);

    player_col = 12'd312; fire = 1'b1; step();  // 933
    chk("re0_inflight", 32'(missile_in_flight), 3'b101);
    fire = 1'b0;
    step_to(940);
    fire = 1'b1; step();            // 941
    chk("re1_inflight", 32'(missile_in_flight), 3'b111);
    chk("re1_count", 32'(in_flight_count), 3);
    fire = 1'b0; step();            // 942
    probe(455, 320, "pre_rst_pix", 3'b001);

    rst = 1'b1;
    #1;
    chk("arst_inflight", 32'(missile_in_flight), 0);
    chk("arst_count", 32'(in_flight_count), 0);
    chk("arst_active", 32'(missile_active), 0);
    chk("arst_out", 32'(missile_output), 0);
    chk("arst_ack", 32'(fire_ack), 0);
    chk("arst_drop", 32'(fire_drop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 0;
    step();                         // 1
    fire = 1'b1; step();            // 2
    chk("post_ack", 32'(fire_ack), 1);
    chk("post_inflight", 32'(missile_in_flight), 3'b001);
    probe(459, 320, "post_spawn", 3'b001);
    fire = 1'b0; step();            // 3
    probe(459, 320, "post_hold", 3'b001);
    step();                         // 4: first tick after restart
    probe(459, 320, "post_mv_old", 3'b000);
    probe(457, 320, "post_mv_new", 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_missile_ctrl.md
Name: player_missile_ctrl

Overview:
Parametrised player missile engine for the VGA Space Invaders peripheral. Owns NUM_MISSILES independent missile slots. Launches on a fire-button rising edge from the player's current column, moves missiles upward on a divided motion tick, and retires them at the screen top or on a collision hit. Produces per-pixel missile overlay and per-slot status for the collision and colour-mux logic.

Parameters:
NUM_MISSILES, 3, number of missile slots (1-8)
COORD_W, 12, width of pixel row/column coordinates
TICK_DIV, 1000000, clk cycles per motion tick (>=2)
MISSILE_STEP, 2, rows moved upward per tick
MISSILE_LEN, 3, missile sprite height term (rows row+1 .. row+MISSILE_LEN-1)
SPAWN_ROW, 458, row loaded at launch
PLAYER_W, 16, player sprite width; launch column = player_col + PLAYER_W/2
COOLDOWN_TICKS, 4, motion ticks after a launch before the next launch is accepted (0 = none)

Ports:
clk  in  1  system clock (31.5 MHz pixel clock domain)
rst  in  1  asynchronous, active-high reset
pixel_row  in  COORD_W  current VGA scan row
pixel_column  in  COORD_W  current VGA scan column
player_col  in  COORD_W  player sprite left column
fire  in  1  fire button level (already debounced)
hit  in  NUM_MISSILES  per-slot collision retire request, one cycle
missile_in_flight  out  NUM_MISSILES  slot i currently flying
missile_active  out  NUM_MISSILES  current pixel lies in missile i (combinational)
missile_output  out  4  4'hF if any missile_active bit set, else 4'h0
in_flight_count  out  $clog2(NUM_MISSILES+1)  popcount of missile_in_flight
fire_ack  out  1  one-cycle pulse: launch accepted
fire_drop  out  1  one-cycle pulse: fire edge rejected (no free slot or cooldown)

Behaviour:
- Reset (async assert, sync release): in_flight=0, row[i]=SPAWN_ROW, col[i]=0, tick counter=0, cooldown=0, fire_ack=fire_drop=0. fire_q resets to 1, so a button held through reset does not launch.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 in the cycle where counter==TICK_DIV-1, giving exactly one tick per TICK_DIV cycles.
- Fire edge: fire_rise = fire & ~fire_q; fire_q <= fire every cycle.
- Launch on fire_rise:
  - Accepted if cooldown==0 and any slot has in_flight==0, using state at the start of the cycle.
  - Selects the lowest-index free slot. Next edge: in_flight=1, row=SPAWN_ROW, col=player_col+PLAYER_W/2 (truncated to COORD_W), cooldown=COOLDOWN_TICKS. fire_ack=1 for one cycle.
  - Otherwise fire_drop=1 for one cycle. There is no queuing.
- Cooldown: decrements by 1 on tick when nonzero. A launch in the same cycle as a tick loads COOLDOWN_TICKS and does not also decrement.
- Motion on tick, per in-flight slot not hit this cycle:
  - If row < MISSILE_STEP: in_flight<=0, row<=SPAWN_ROW.
  - Else row <= row-MISSILE_STEP. Column is unchanged after launch.
- A slot launched this cycle is not moved by a coincident tick; its first move is on the next tick.
- Hit: hit[i] with in_flight[i]=1 forces in_flight<=0, row<=SPAWN_ROW next edge, taking priority over motion. hit[i] on an idle slot is ignored. The slot is free for launch from the following cycle; a same-cycle fire_rise must select another slot or drop.
- Pixel: missile_active[i] = in_flight[i] & (row[i] < pixel_row) & (pixel_row < row[i]+MISSILE_LEN) & (pixel_column == col[i]). Compare in COORD_W+1 bits so there is no wrap. missile_output and in_flight_count are combinational from the registers.
- Reset mid-flight: all slots clear immediately, outputs return to reset values, and no pulse is emitted.

Test Plan:
- Reset with fire held high, release, keep fire high 10 cycles -> no fire_ack, in_flight_count=0; drop fire, raise -> fire_ack 1 cycle later, slot0 row=458, col=player_col+8.
- TICK_DIV=4, one launch, player_col=312 -> row 458,456,454... every 4 cycles; pixel (row+1..row+2, col 320) gives missile_output=4'hF; pixel col 321 gives 0; retires after the tick where row<2, in_flight_count back to 0.
- COOLDOWN_TICKS=0, three fire edges then a fourth -> slots 0,1,2 filled in order, fourth gives fire_drop and count stays 3.
- COOLDOWN_TICKS=2, fire edges at tick 0 and tick 1 -> second dropped; edge after 2 ticks accepted.
- hit[1] asserted with slot1 flying and fire_rise in the same cycle (slot0 busy, slot2 free) -> slot1 cleared, launch goes to slot2; hit[2] on an idle slot changes nothing.
- Assert rst with 3 missiles in flight mid-tick -> all outputs 0 asynchronously, rows 458, counter restarts at 0.
